// File: rtl/bitstream_decoder_array.sv
// ---------------------------------------------------------------------------
// bitstream_decoder_array
//
// Turns an array of signed stochastic bitstream pairs back into signed binary
// counts. Each element accumulates (p - m) over a window of 2^WINDOW_BITS
// accepted samples. At the end of each window, all element results are
// presented together on a registered valid/ready port.
//
// Parameters
//   NUM_ELEMENTS : number of p/m bitstream pairs
//   WINDOW_BITS  : log2 of the window length in accepted samples (1..24)
//
// Ports
//   CLK        : clock, rising edge
//   RST        : asynchronous active-high reset
//   in_p/in_m  : plus/minus channel bits, element i on bit i
//   in_en      : sample strobe
//   clr        : synchronous clear of the window in progress (beats in_en)
//   out_data   : packed signed results, element i at [i*OW +: OW], OW=WINDOW_BITS+2
//   out_valid  : out_data holds an unconsumed result
//   out_ready  : consumer takes out_data when out_valid && out_ready
//   overrun    : one-cycle pulse after an unconsumed result was overwritten
// ---------------------------------------------------------------------------
module bitstream_decoder_array #(
  parameter int NUM_ELEMENTS = 1,
  parameter int WINDOW_BITS  = 10
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic [NUM_ELEMENTS-1:0]                    in_p,
  input  logic [NUM_ELEMENTS-1:0]                    in_m,
  input  logic                                       in_en,
  input  logic                                       clr,
  output logic [NUM_ELEMENTS*(WINDOW_BITS+2)-1:0]    out_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       overrun
);

  // Two bits of headroom: the range is +/-2^WINDOW_BITS, which needs
  // WINDOW_BITS+1 magnitude bits plus a sign bit, so there is no saturation.
  localparam int OUT_BITWIDTH = WINDOW_BITS + 2;

  typedef logic signed [OUT_BITWIDTH-1:0] acc_t;

  localparam acc_t                   ACC_PLUS_ONE  = acc_t'(1'b1);
  localparam acc_t                   ACC_MINUS_ONE = {OUT_BITWIDTH{1'b1}};
  localparam acc_t                   ACC_ZERO      = {OUT_BITWIDTH{1'b0}};
  localparam logic [WINDOW_BITS-1:0] WCNT_ONE      = WINDOW_BITS'(1'b1);
  localparam logic [WINDOW_BITS-1:0] WCNT_ZERO     = {WINDOW_BITS{1'b0}};
  localparam logic [WINDOW_BITS-1:0] WCNT_LAST     = {WINDOW_BITS{1'b1}};

  // Signed contribution of one sample pair: +1, -1, or 0 when p == m.
  function automatic acc_t contrib_f(input logic p, input logic m);
    acc_t c;
    case ({p, m})
      2'b10:   c = ACC_PLUS_ONE;
      2'b01:   c = ACC_MINUS_ONE;
      default: c = ACC_ZERO;
    endcase
    return c;
  endfunction

  // State
  acc_t                                     acc_q [NUM_ELEMENTS];
  acc_t                                     acc_d [NUM_ELEMENTS];
  acc_t                                     sum_s [NUM_ELEMENTS];
  logic [WINDOW_BITS-1:0]                   wcnt_q;
  logic [WINDOW_BITS-1:0]                   wcnt_d;
  logic [NUM_ELEMENTS*OUT_BITWIDTH-1:0]     out_data_q;
  logic [NUM_ELEMENTS*OUT_BITWIDTH-1:0]     out_data_d;
  logic                                     out_valid_q;
  logic                                     out_valid_d;
  logic                                     overrun_q;
  logic                                     overrun_d;

  logic accept_s;
  logic window_end_s;
  logic consume_s;

  assign accept_s     = in_en & ~clr;
  assign window_end_s = accept_s & (wcnt_q == WCNT_LAST);
  assign consume_s    = out_valid_q & out_ready;

  // Running sum including the current sample. It feeds both the accumulators
  // and the result register, so the final sample of a window is never lost.
  always_comb begin
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      sum_s[i] = acc_q[i] + contrib_f(in_p[i], in_m[i]);
    end
  end

  // Next-state logic for the accumulators, window counter and output port.
  always_comb begin
    acc_d       = acc_q;
    wcnt_d      = wcnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;

    if (clr) begin
      // Clear wins over a coincident window end. No result is produced.
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        acc_d[i] = ACC_ZERO;
      end
      wcnt_d      = WCNT_ZERO;
      out_valid_d = 1'b0;
    end else if (window_end_s) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        out_data_d[i*OUT_BITWIDTH +: OUT_BITWIDTH] = sum_s[i];
        acc_d[i] = ACC_ZERO;
      end
      wcnt_d      = WCNT_ZERO;
      // The new result keeps valid high even if the old one is consumed now.
      out_valid_d = 1'b1;
      overrun_d   = out_valid_q & ~out_ready;
    end else begin
      if (accept_s) begin
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
          acc_d[i] = sum_s[i];
        end
        wcnt_d = wcnt_q + WCNT_ONE;
      end else begin
        wcnt_d = wcnt_q;
      end

      if (consume_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        acc_q[i] <= ACC_ZERO;
      end
      wcnt_q      <= WCNT_ZERO;
      out_data_q  <= {(NUM_ELEMENTS*OUT_BITWIDTH){1'b0}};
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        acc_q[i] <= acc_d[i];
      end
      wcnt_q      <= wcnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_bitstream_decoder_array.sv
// ---------------------------------------------------------------------------
// Testbench for bitstream_decoder_array with NUM_ELEMENTS=3 and WINDOW_BITS=4.
// It drives one sample per clock through step(). A behavioural model pushes
// each expected window result into a scoreboard queue. The queue entry is
// popped and compared on the cycle the result must be visible. Table vectors
// cover constant streams. Hand-written sequences cover gaps, overrun, consume
// on window end, clear and reset.
// ---------------------------------------------------------------------------
module tb_bitstream_decoder_array;

  localparam int NE   = 3;
  localparam int WB   = 4;
  localparam int OW   = WB + 2;
  localparam int WLEN = 16;

  logic          CLK;
  logic          RST;
  logic [NE-1:0] in_p;
  logic [NE-1:0] in_m;
  logic          in_en;
  logic          clr;
  logic [NE*OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;

  bitstream_decoder_array #(
    .NUM_ELEMENTS(NE),
    .WINDOW_BITS (WB)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_p     (in_p),
    .in_m     (in_m),
    .in_en    (in_en),
    .clr      (clr),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int               m_acc [NE];
  int               m_wcnt;
  logic [NE*OW-1:0] m_data;
  bit               m_valid;
  bit               m_ovr;
  logic [NE*OW-1:0] sb_q [$];

  typedef struct packed {
    logic [NE-1:0] p;
    logic [NE-1:0] m;
    logic [OW-1:0] e0;
    logic [OW-1:0] e1;
    logic [OW-1:0] e2;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int contr(input logic p, input logic m);
    if (p && !m) return 1;
    else if (!p && m) return -1;
    else return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) m_acc[i] = 0;
    m_wcnt  = 0;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    sb_q.delete();
  endtask

  // Drives one clock of stimulus, advances the model, then checks after the edge.
  task automatic step(input logic [NE-1:0] p, input logic [NE-1:0] m,
                      input logic en, input logic c, input logic rdy);
    logic [NE*OW-1:0] pk;
    bit               wend;
    int               s;
    in_p = p; in_m = m; in_en = en; clr = c; out_ready = rdy;
    pk   = '0;
    wend = en && !c && (m_wcnt == WLEN-1);
    if (c) begin
      for (int i = 0; i < NE; i++) m_acc[i] = 0;
      m_wcnt  = 0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      m_ovr = wend && m_valid && !rdy;
      if (wend) begin
        for (int i = 0; i < NE; i++) begin
          s = m_acc[i] + contr(p[i], m[i]);
          pk[i*OW +: OW] = s[OW-1:0];
          m_acc[i] = 0;
        end
        sb_q.push_back(pk);
        m_wcnt  = 0;
        m_valid = 1'b1;
      end else begin
        if (en) begin
          for (int i = 0; i < NE; i++) m_acc[i] = m_acc[i] + contr(p[i], m[i]);
          m_wcnt = m_wcnt + 1;
        end
        if (m_valid && rdy) m_valid = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
    if (wend) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        m_data = sb_q.pop_front();
      end
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
    chk("out_data",  {14'd0, out_data},  {14'd0, m_data});
  endtask

  // Pulses RST between clock edges and checks the outputs before the next edge.
  task automatic pulse_reset();
    #1 RST = 1'b1;
    #1;
    model_reset();
    chk("rst_data",    {14'd0, out_data}, 32'd0);
    chk("rst_valid",   {31'd0, out_valid}, 32'd0);
    chk("rst_overrun", {31'd0, overrun},  32'd0);
    #2 RST = 1'b0;
  endtask

  initial begin
    logic [NE-1:0] rp;
    logic [NE-1:0] rm;
    int            gaps;

    vecs[0] = '{p: 3'b101, m: 3'b110, e0: 6'h10, e1: 6'h30, e2: 6'h00};
    vecs[1] = '{p: 3'b010, m: 3'b001, e0: 6'h30, e1: 6'h10, e2: 6'h00};
    vecs[2] = '{p: 3'b000, m: 3'b000, e0: 6'h00, e1: 6'h00, e2: 6'h00};
    vecs[3] = '{p: 3'b111, m: 3'b000, e0: 6'h10, e1: 6'h10, e2: 6'h10};

    RST = 1'b1; in_p = '0; in_m = '0; in_en = 1'b0; clr = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("init_data",  {14'd0, out_data}, 32'd0);
    chk("init_valid", {31'd0, out_valid}, 32'd0);
    RST = 1'b0;

    // Constant streams from the table
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < WLEN; k++) step(vecs[v].p, vecs[v].m, 1'b1, 1'b0, 1'b1);
      chk("tbl_valid", {31'd0, out_valid}, 32'd1);
      chk("tbl_e0", {26'd0, out_data[0*OW +: OW]}, {26'd0, vecs[v].e0});
      chk("tbl_e1", {26'd0, out_data[1*OW +: OW]}, {26'd0, vecs[v].e1});
      chk("tbl_e2", {26'd0, out_data[2*OW +: OW]}, {26'd0, vecs[v].e2});
    end
    step(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);

    // Gapped mixed input: e0 has 12 plus samples and 4 minus samples
    for (int k = 0; k < WLEN; k++) begin
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        rp = NE'($urandom); rm = NE'($urandom);
        step(rp, rm, 1'b0, 1'b0, 1'b0);
      end
      rp = NE'($urandom); rm = NE'($urandom);
      rp[0] = (k % 4 != 3);
      rm[0] = (k % 4 == 3);
      step(rp, rm, 1'b1, 1'b0, 1'b0);
    end
    chk("gap_valid", {31'd0, out_valid}, 32'd1);
    chk("gap_e0", {26'd0, out_data[0 +: OW]}, 32'd8);
    step(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);

    // Back-to-back overrun with out_ready low
    for (int k = 0; k < WLEN; k++) step(3'b001, 3'b100, 1'b1, 1'b0, 1'b0);
    chk("ovr_first_none", {31'd0, overrun}, 32'd0);
    for (int k = 0; k < WLEN; k++) step(3'b110, 3'b001, 1'b1, 1'b0, 1'b0);
    chk("ovr_pulse", {31'd0, overrun}, 32'd1);
    chk("ovr_data",  {14'd0, out_data}, {14'd0, 6'h10, 6'h10, 6'h30});
    step(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("ovr_one_cycle", {31'd0, overrun}, 32'd0);
    chk("ovr_valid_hold", {31'd0, out_valid}, 32'd1);
    step(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("ready_drop", {31'd0, out_valid}, 32'd0);

    // Consume on the same cycle as a window end
    for (int k = 0; k < WLEN; k++) step(3'b111, 3'b000, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < WLEN; k++) step(3'b000, 3'b111, 1'b1, 1'b0, (k == WLEN-1));
    chk("cons_valid",   {31'd0, out_valid}, 32'd1);
    chk("cons_overrun", {31'd0, overrun}, 32'd0);
    chk("cons_data",    {14'd0, out_data}, {14'd0, 6'h30, 6'h30, 6'h30});
    step(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);

    // Clear mid-window (clr coincides with in_en to exercise priority)
    for (int k = 0; k < 7; k++) step(3'b111, 3'b000, 1'b1, 1'b0, 1'b0);
    step(3'b111, 3'b000, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) step(3'b111, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("clr_no_result", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 7; k++) step(3'b111, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("clr_result_valid", {31'd0, out_valid}, 32'd1);
    chk("clr_result_data",  {14'd0, out_data}, {14'd0, 6'h10, 6'h10, 6'h10});
    step(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);

    // Reset mid-window
    for (int k = 0; k < 7; k++) step(3'b010, 3'b101, 1'b1, 1'b0, 1'b0);
    pulse_reset();
    for (int k = 0; k < 9; k++) step(3'b010, 3'b101, 1'b1, 1'b0, 1'b0);
    chk("rst_no_result", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 7; k++) step(3'b010, 3'b101, 1'b1, 1'b0, 1'b0);
    chk("rst_result_valid", {31'd0, out_valid}, 32'd1);
    chk("rst_result_data",  {14'd0, out_data}, {14'd0, 6'h30, 6'h10, 6'h30});
    step(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);

    // Clear on the window-end sample: no result is produced
    for (int k = 0; k < WLEN-1; k++) step(3'b100, 3'b000, 1'b1, 1'b0, 1'b0);
    step(3'b100, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("clr_wend_valid", {31'd0, out_valid}, 32'd0);
    step(3'b100, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("clr_wend_after", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
